// File: rtl/hash_cmd_pkg.sv
// Shared definitions for the hash table command sequencer: command op codes,
// response status codes and the sequencer FSM state type.
// No ports (package).
package hash_cmd_pkg;

    typedef logic [1:0] op_t;
    typedef logic [1:0] status_t;

    localparam op_t OP_INSERT  = 2'b00;
    localparam op_t OP_DELETE  = 2'b01;
    localparam op_t OP_SEARCH  = 2'b10;
    localparam op_t OP_ILLEGAL = 2'b11;

    localparam status_t ST_OK        = 2'b00;
    localparam status_t ST_TABLE_ERR = 2'b01;
    localparam status_t ST_TIMEOUT   = 2'b10;
    localparam status_t ST_ILLEGAL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/hash_cmd_sequencer_if.sv
// Command/response stream bundle between a client and hash_cmd_sequencer.
// Command channel: cmd_valid/cmd_ready handshake carrying op, key, value, tag.
// Response channel: rsp_valid/rsp_ready handshake carrying tag, op, value,
// status. The master modport is the client, the slave modport the sequencer.
interface hash_cmd_sequencer_if
    import hash_cmd_pkg::*;
#(
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 32,
    parameter int TAG_WIDTH   = 4
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    op_t                    cmd_op;
    logic [KEY_WIDTH-1:0]   cmd_key;
    logic [VALUE_WIDTH-1:0] cmd_value;
    logic [TAG_WIDTH-1:0]   cmd_tag;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [TAG_WIDTH-1:0]   rsp_tag;
    op_t                    rsp_op;
    logic [VALUE_WIDTH-1:0] rsp_value;
    status_t                rsp_status;

    modport master (
        output cmd_valid, cmd_op, cmd_key, cmd_value, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_tag, rsp_op, rsp_value, rsp_status
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_key, cmd_value, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_tag, rsp_op, rsp_value, rsp_status
    );
endinterface

// File: rtl/hash_cmd_fifo.sv
// Synchronous FIFO holding packed commands for the sequencer.
// Ports: clk, rst_n (sync, active-low), push/din write side, pop read side,
// dout = current head entry (valid whenever count != 0), count = occupancy.
// The caller guarantees no push when full and no pop when empty.
module hash_cmd_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];
endmodule

// File: rtl/hash_cmd_sequencer.sv
// Command front-end for hash_table: buffers tagged insert/delete/search
// commands, issues them one at a time on the table's op_en/op_done handshake
// and returns one tagged response (value + status) per command, in order.
// Ports: clk, rst_n (sync, active-low); bus = command/response streams
// (slave side); ht_* = straight connection to hash_table; pending_count =
// FIFO occupancy plus one while a command is being issued or answered.
module hash_cmd_sequencer
    import hash_cmd_pkg::*;
#(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 32,
    parameter int TAG_WIDTH      = 4,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    hash_cmd_sequencer_if.slave            bus,
    output logic [KEY_WIDTH-1:0]           ht_key_in,
    output logic [VALUE_WIDTH-1:0]         ht_value_in,
    output op_t                            ht_op_sel,
    output logic                           ht_op_en,
    input  logic [VALUE_WIDTH-1:0]         ht_value_out,
    input  logic                           ht_op_done,
    input  logic                           ht_op_error,
    output logic [$clog2(CMD_DEPTH+1):0]   pending_count
);
    localparam int CW = $clog2(CMD_DEPTH+1);
    localparam int PW = CW + 1;
    localparam int EW = 2 + KEY_WIDTH + VALUE_WIDTH + TAG_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES+1);

    logic [CW-1:0]          fifo_count;
    logic [EW-1:0]          head;
    logic                   push;
    logic                   pop;
    logic                   fifo_seen;
    op_t                    head_op;
    logic [KEY_WIDTH-1:0]   head_key;
    logic [VALUE_WIDTH-1:0] head_value;
    logic [TAG_WIDTH-1:0]   head_tag;
    state_e                 state;
    state_e                 next_state;
    logic [TW-1:0]          tmo_cnt;
    logic                   tmo_hit;

    assign bus.cmd_ready = fifo_count < CW'(CMD_DEPTH);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign {head_op, head_key, head_value, head_tag} = head;
    assign tmo_hit       = tmo_cnt == TW'(TIMEOUT_CYCLES-1);
    assign bus.rsp_valid = state == RESP;
    assign pending_count = PW'(fifo_count) + PW'(state != IDLE);

    hash_cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({bus.cmd_op, bus.cmd_key, bus.cmd_value, bus.cmd_tag}),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // The op_done gate in IDLE keeps op_en low for at least one cycle between
    // operations and stops a late op_done from being taken for the next one.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_seen && fifo_count != '0 && !ht_op_done) begin
                    pop        = 1'b1;
                    next_state = (head_op == OP_ILLEGAL) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (ht_op_done || tmo_hit) next_state = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The FSM looks at occupancy through a registered flag, so an entry
    // written on the accept edge is popped on the second edge after it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_seen      <= 1'b0;
            tmo_cnt        <= '0;
            ht_key_in      <= '0;
            ht_value_in    <= '0;
            ht_op_sel      <= OP_INSERT;
            ht_op_en       <= 1'b0;
            bus.rsp_tag    <= '0;
            bus.rsp_op     <= OP_INSERT;
            bus.rsp_value  <= '0;
            bus.rsp_status <= ST_OK;
        end else begin
            fifo_seen <= fifo_count != '0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.rsp_tag   <= head_tag;
                        bus.rsp_op    <= head_op;
                        bus.rsp_value <= '0;
                        if (head_op == OP_ILLEGAL) begin
                            bus.rsp_status <= ST_ILLEGAL;
                        end else begin
                            ht_key_in   <= head_key;
                            ht_value_in <= head_value;
                            ht_op_sel   <= head_op;
                            ht_op_en    <= 1'b1;
                            tmo_cnt     <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (ht_op_done) begin
                        ht_op_en       <= 1'b0;
                        bus.rsp_status <= ht_op_error ? ST_TABLE_ERR : ST_OK;
                        bus.rsp_value  <= (ht_op_sel == OP_SEARCH && !ht_op_error)
                                          ? ht_value_out : '0;
                    end else if (tmo_hit) begin
                        ht_op_en       <= 1'b0;
                        bus.rsp_status <= ST_TIMEOUT;
                        bus.rsp_value  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hash_cmd_sequencer.sv
module tb_hash_cmd_sequencer;
    import hash_cmd_pkg::*;

    localparam int KW = 32;
    localparam int VW = 32;
    localparam int TW = 4;
    localparam int DEPTH = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hash_cmd_sequencer_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TAG_WIDTH(TW)) bus ();

    logic [KW-1:0] ht_key_in;
    logic [VW-1:0] ht_value_in;
    logic [1:0]    ht_op_sel;
    logic          ht_op_en;
    logic [VW-1:0] ht_value_out;
    logic          ht_op_done;
    logic          ht_op_error;
    logic [3:0]    pending_count;

    hash_cmd_sequencer #(
        .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TAG_WIDTH(TW),
        .CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .ht_key_in(ht_key_in), .ht_value_in(ht_value_in), .ht_op_sel(ht_op_sel),
        .ht_op_en(ht_op_en), .ht_value_out(ht_value_out), .ht_op_done(ht_op_done),
        .ht_op_error(ht_op_error), .pending_count(pending_count)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [TW-1:0] tag;
        logic [1:0]    op;
        logic [VW-1:0] value;
        logic [1:0]    status;
    } rsp_t;
    rsp_t exp_q[$];
    int   hs_cyc[$];

    // ---------------- table responder (stand-in for hash_table) ----------------
    logic [KW-1:0] tk [8][4];
    logic [VW-1:0] tv [8][4];
    logic          tu [8][4];
    bit  served, busy, never_done;
    int  wait_cnt, lat_mode, lat_now, tb_b, tb_hit, tb_free;

    always @(posedge clk) begin
        if (!rst_n) begin
            ht_op_done   <= 1'b0;
            ht_op_error  <= 1'b0;
            ht_value_out <= '0;
            served       <= 1'b0;
            busy         <= 1'b0;
            for (int b = 0; b < 8; b++)
                for (int w = 0; w < 4; w++) tu[b][w] <= 1'b0;
        end else begin
            ht_op_done <= 1'b0;
            if (!ht_op_en) served <= 1'b0;
            lat_now = (lat_mode == 0) ? 1 : int'($urandom_range(1, 3));
            if ((!busy && ht_op_en && !served && !never_done && lat_now == 1) ||
                (busy && wait_cnt == 0)) begin
                busy   <= 1'b0;
                served <= 1'b1;
                ht_op_done <= 1'b1;
                tb_b = int'(ht_key_in[2:0]);
                tb_hit = -1;
                tb_free = -1;
                for (int w = 3; w >= 0; w--) begin
                    if (tu[tb_b][w] && tk[tb_b][w] == ht_key_in) tb_hit = w;
                    if (!tu[tb_b][w]) tb_free = w;
                end
                ht_value_out <= $urandom;
                ht_op_error  <= 1'b0;
                case (ht_op_sel)
                    2'b00: begin
                        if (tb_hit >= 0) tv[tb_b][tb_hit] <= ht_value_in;
                        else if (tb_free >= 0) begin
                            tu[tb_b][tb_free] <= 1'b1;
                            tk[tb_b][tb_free] <= ht_key_in;
                            tv[tb_b][tb_free] <= ht_value_in;
                        end else ht_op_error <= 1'b1;
                    end
                    2'b01: begin
                        if (tb_hit >= 0) tu[tb_b][tb_hit] <= 1'b0;
                        else ht_op_error <= 1'b1;
                    end
                    2'b10: begin
                        if (tb_hit >= 0) ht_value_out <= tv[tb_b][tb_hit];
                        else ht_op_error <= 1'b1;
                    end
                    default: ht_op_error <= 1'b1;
                endcase
            end else if (!busy && ht_op_en && !served && !never_done) begin
                busy     <= 1'b1;
                wait_cnt <= lat_now - 2;
            end else if (busy) begin
                wait_cnt <= wait_cnt - 1;
            end
        end
    end

    // ---------------- reference model (command level) ----------------
    logic [VW-1:0] ref_kv [logic [KW-1:0]];
    int ref_fill [8];

    task automatic model_expect(input logic [1:0] op, input logic [KW-1:0] key,
                                input logic [VW-1:0] val, input logic [TW-1:0] tag);
        rsp_t r;
        int bk;
        bk = int'(key % 8);
        r.tag = tag; r.op = op; r.value = '0; r.status = ST_OK;
        case (op)
            OP_INSERT: begin
                if (ref_kv.exists(key)) ref_kv[key] = val;
                else if (ref_fill[bk] >= 4) r.status = ST_TABLE_ERR;
                else begin ref_kv[key] = val; ref_fill[bk]++; end
            end
            OP_DELETE: begin
                if (ref_kv.exists(key)) begin ref_kv.delete(key); ref_fill[bk]--; end
                else r.status = ST_TABLE_ERR;
            end
            OP_SEARCH: begin
                if (ref_kv.exists(key)) r.value = ref_kv[key];
                else r.status = ST_TABLE_ERR;
            end
            default: r.status = ST_ILLEGAL;
        endcase
        exp_q.push_back(r);
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // response monitor: handshake completes on the following rising edge
    initial forever begin
        rsp_t e;
        @(negedge clk);
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            hs_cyc.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected got tag=%0d op=%0d status=%0d value=%0h",
                         bus.rsp_tag, bus.rsp_op, bus.rsp_status, bus.rsp_value);
            end else begin
                e = exp_q.pop_front();
                if (bus.rsp_tag !== e.tag || bus.rsp_op !== e.op ||
                    bus.rsp_status !== e.status || bus.rsp_value !== e.value) begin
                    bad++;
                    $display("FAIL rsp got tag=%0d op=%0d status=%0d value=%0h want tag=%0d op=%0d status=%0d value=%0h",
                             bus.rsp_tag, bus.rsp_op, bus.rsp_status, bus.rsp_value,
                             e.tag, e.op, e.status, e.value);
                end
            end
        end
    end

    bit rand_rdy = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) bus.rsp_ready = ($urandom % 4) != 0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic set_rdy(input logic v);
        @(posedge clk);
        #1 bus.rsp_ready = v;
    endtask

    task automatic push(input logic [1:0] op, input logic [KW-1:0] key,
                        input logic [VW-1:0] val, input logic [TW-1:0] tag);
        bit ok = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_key = key;
        bus.cmd_value = val; bus.cmd_tag = tag;
        for (int n = 0; n < 400; n++) begin
            if (bus.cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        else begin
            total++; bad++;
            $display("FAIL push_wait got=cmd_ready_low want=accepted");
        end
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int n = 0; n < 3000; n++) begin
            if (exp_q.size() == 0) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL drain got=%0d_outstanding want=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        exp_q.delete();
        ref_kv.delete();
        for (int i = 0; i < 8; i++) ref_fill[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [KW-1:0] key;
        logic [VW-1:0] val;
        logic [TW-1:0] tag;
        logic [1:0]    st;
        logic [VW-1:0] ev;
    } vec_t;
    vec_t vecs [12];

    initial begin
        int hi;
        logic [1:0] op;
        int r;
        vecs[0]  = '{OP_INSERT, 1,  2,  3,  ST_OK,        0};
        vecs[1]  = '{OP_SEARCH, 1,  0,  4,  ST_OK,        2};
        vecs[2]  = '{OP_DELETE, 1,  0,  5,  ST_OK,        0};
        vecs[3]  = '{OP_DELETE, 1,  0,  6,  ST_TABLE_ERR, 0};
        vecs[4]  = '{OP_SEARCH, 1,  0,  7,  ST_TABLE_ERR, 0};
        vecs[5]  = '{OP_INSERT, 3,  30, 8,  ST_OK,        0};
        vecs[6]  = '{OP_INSERT, 11, 31, 9,  ST_OK,        0};
        vecs[7]  = '{OP_INSERT, 19, 32, 10, ST_OK,        0};
        vecs[8]  = '{OP_INSERT, 27, 33, 11, ST_OK,        0};
        vecs[9]  = '{OP_INSERT, 35, 34, 12, ST_TABLE_ERR, 0};
        vecs[10] = '{OP_SEARCH, 27, 0,  13, ST_OK,        33};
        vecs[11] = '{OP_SEARCH, 35, 0,  14, ST_TABLE_ERR, 0};

        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_key = 0; bus.cmd_value = 0;
        bus.cmd_tag = 0; bus.rsp_ready = 0;
        never_done = 0; lat_mode = 0;

        // reset values
        do_reset();
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_fields", {bus.rsp_tag, bus.rsp_op, bus.rsp_status, bus.rsp_value}, 0);
        chk("rst_ht_en", ht_op_en, 0);
        chk("rst_ht_fields", {ht_key_in, ht_value_in, ht_op_sel}, 0);
        chk("rst_pending", pending_count, 0);

        // issue latency and completion timing, 1-cycle table
        set_rdy(1);
        model_expect(OP_INSERT, 5, 32'h55, 1);
        push(OP_INSERT, 5, 32'h55, 1);
        chk("issue_n0", ht_op_en, 0);
        @(posedge clk); #1 chk("issue_n1", ht_op_en, 0);
        @(posedge clk); #1 chk("issue_n2", ht_op_en, 1);
        chk("issue_key", ht_key_in, 5);
        @(posedge clk); #1 chk("table_done", ht_op_done, 1);
        @(posedge clk); #1 chk("done_en_low", ht_op_en, 0);
        chk("done_rsp_valid", bus.rsp_valid, 1);
        wait_drain();

        // illegal op: no issue, response right after the pop edge
        model_expect(OP_ILLEGAL, 0, 0, 7);
        push(OP_ILLEGAL, 0, 0, 7);
        chk("ill_n0_valid", bus.rsp_valid, 0);
        @(posedge clk); #1 chk("ill_n1_valid", bus.rsp_valid, 0);
        chk("ill_n1_en", ht_op_en, 0);
        @(posedge clk); #1 chk("ill_n2_valid", bus.rsp_valid, 1);
        chk("ill_n2_en", ht_op_en, 0);
        wait_drain();

        // table-driven vectors
        do_reset();
        lat_mode = 1;
        set_rdy(1);
        for (int i = 0; i < 12; i++) begin
            rsp_t e;
            e.tag = vecs[i].tag; e.op = vecs[i].op; e.value = vecs[i].ev; e.status = vecs[i].st;
            exp_q.push_back(e);
            push(vecs[i].op, vecs[i].key, vecs[i].val, vecs[i].tag);
        end
        wait_drain();
        chk("vec_pending", pending_count, 0);

        // throughput: back-to-back, 1-cycle table, rsp_ready high
        do_reset();
        lat_mode = 0;
        set_rdy(1);
        hs_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            model_expect(OP_INSERT, 40 + i, 100 + i, i[3:0]);
            push(OP_INSERT, 40 + i, 100 + i, i[3:0]);
        end
        wait_drain();
        chk("tput_count", hs_cyc.size(), 4);
        if (hs_cyc.size() == 4)
            for (int i = 1; i < 4; i++) chk("tput_gap", hs_cyc[i] - hs_cyc[i-1], 4);

        // backpressure: FIFO fills while the FSM stalls in RESP
        do_reset();
        lat_mode = 1;
        set_rdy(0);
        for (int i = 0; i < 5; i++) begin
            model_expect(OP_INSERT, 100 + i, 200 + i, 4'(8 + i));
            push(OP_INSERT, 100 + i, 200 + i, 4'(8 + i));
        end
        chk("bp_ready_low", bus.cmd_ready, 0);
        chk("bp_pending5", pending_count, 5);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_stall_valid", bus.rsp_valid, 1);
        chk("bp_stall_pending", pending_count, 5);
        chk("bp_stall_ready", bus.cmd_ready, 0);
        set_rdy(1);
        wait_drain();
        chk("bp_pending0", pending_count, 0);
        chk("bp_ready_back", bus.cmd_ready, 1);

        // timeout: table never answers
        do_reset();
        never_done = 1;
        set_rdy(1);
        begin
            rsp_t e;
            e.tag = 1; e.op = OP_INSERT; e.value = 0; e.status = ST_TIMEOUT;
            exp_q.push_back(e);
        end
        push(OP_INSERT, 9, 9, 1);
        hi = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (ht_op_en) hi++;
            else if (hi > 0) break;
        end
        chk("tmo_len", hi, TMO);
        chk("tmo_rsp_valid", bus.rsp_valid, 1);
        wait_drain();

        // reset while an operation is in flight and another is queued
        do_reset();
        never_done = 1;
        push(OP_INSERT, 9, 9, 2);
        push(OP_INSERT, 10, 10, 3);
        repeat (4) @(posedge clk);
        #1 chk("mid_issue_en", ht_op_en, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_cmd_ready", bus.cmd_ready, 1);
        chk("mrst_rsp_valid", bus.rsp_valid, 0);
        chk("mrst_rsp_fields", {bus.rsp_tag, bus.rsp_op, bus.rsp_status, bus.rsp_value}, 0);
        chk("mrst_ht_en", ht_op_en, 0);
        chk("mrst_ht_fields", {ht_key_in, ht_value_in, ht_op_sel}, 0);
        chk("mrst_pending", pending_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        never_done = 0;
        repeat (20) @(posedge clk);
        #1 chk("mrst_quiet", pending_count, 0);

        // randomized traffic against the command-level model
        do_reset();
        lat_mode = 1;
        rand_rdy = 1;
        for (int i = 0; i < 80; i++) begin
            logic [KW-1:0] k;
            logic [VW-1:0] v;
            r = int'($urandom % 16);
            op = (r < 6) ? OP_INSERT : (r < 9) ? OP_DELETE : (r < 15) ? OP_SEARCH : OP_ILLEGAL;
            k = $urandom % 24;
            v = $urandom;
            model_expect(op, k, v, 4'(i));
            push(op, k, v, 4'(i));
            repeat ($urandom % 3) @(posedge clk);
        end
        @(posedge clk);
        #2 rand_rdy = 0;
        bus.rsp_ready = 1;
        wait_drain();
        chk("rand_pending", pending_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
